// File: rtl/photon_cop_pkg.sv
// Shared constants and types for the photon step co-processor sequencer.
package photon_cop_pkg;
  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  localparam logic [3:0] STEP_FUNCT_HI = 4'b0000;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } cop_state_e;
endpackage

// File: rtl/photon_cop_dec.sv
// Combinational decode of the photon step custom instruction.
module photon_cop_dec
  import photon_cop_pkg::*;
#(
  parameter logic [1:0] ISE_V = 2'b10
) (
  input  logic [31:0] insn,
  output logic        sel,
  output logic [2:0]  imm
);
  assign sel = ISE_V[1] & (insn[6:0] == CUSTOM_1) & (insn[31:28] == STEP_FUNCT_HI);
  assign imm = insn[27:25];
endmodule

// File: rtl/photon_cop_ctrl.sv
// Sequencer: accepts a photon step, runs the shared datapath LAT cycles,
// then holds the result on write-back until the core takes it.
module photon_cop_ctrl
  import photon_cop_pkg::*;
#(
  parameter logic [1:0] ISE_V = 2'b10,
  parameter int         LAT   = 2
) (
  input  logic        cop_clk,
  input  logic        cop_rst,
  input  logic        cop_valid,
  input  logic        cop_rdywr,
  output logic        cop_ready,
  output logic        cop_wait,
  output logic        cop_wr,
  input  logic [31:0] cop_insn,
  input  logic [31:0] cop_rs1,
  input  logic [31:0] cop_rs2,
  output logic [31:0] cop_rd,
  output logic        dp_step,
  output logic [31:0] dp_rs1,
  output logic [31:0] dp_rs2,
  output logic [2:0]  dp_imm,
  input  logic [31:0] dp_rd,
  output logic [15:0] stat_ops
);
  if ((LAT < LAT_MIN) || (LAT > LAT_MAX)) begin : g_bad_lat
    $error("photon_cop_ctrl: LAT must be within 1..7");
  end

  cop_state_e  state;
  logic [2:0]  cnt;
  logic [31:0] rs1_q, rs2_q, res_q;
  logic [2:0]  imm_q;
  logic [15:0] stat_q;
  logic        sel;
  logic [2:0]  imm_d;

  photon_cop_dec #(.ISE_V(ISE_V)) u_dec (
    .insn (cop_insn),
    .sel  (sel),
    .imm  (imm_d)
  );

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      res_q  <= '0;
      stat_q <= '0;
    end else begin
      case (state)
        IDLE: if (cop_valid && sel) begin
          rs1_q <= cop_rs1;
          rs2_q <= cop_rs2;
          imm_q <= imm_d;
          cnt   <= 3'(LAT - 1);
          state <= EXEC;
        end
        // cnt counts down the remaining datapath cycles; capture on the last
        EXEC: if (cnt == 3'd0) begin
          res_q <= dp_rd;
          state <= RESP;
        end else begin
          cnt <= cnt - 3'd1;
        end
        RESP: if (cop_rdywr) begin
          stat_q <= stat_q + 16'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic exec, resp;
  assign exec = (state == EXEC);
  assign resp = (state == RESP);

  assign cop_ready = (state == IDLE) | (resp & cop_rdywr);
  assign cop_wait  = exec;
  assign cop_wr    = resp;
  assign cop_rd    = resp ? res_q : 32'd0;
  assign dp_step   = exec;
  assign dp_rs1    = exec ? rs1_q : 32'd0;
  assign dp_rs2    = exec ? rs2_q : 32'd0;
  assign dp_imm    = exec ? imm_q : 3'd0;
  assign stat_ops  = stat_q;
endmodule

// File: tb/tb_photon_cop_ctrl.sv
// Directed table-driven bench for photon_cop_ctrl (LAT=2, LAT=1, ISE disabled).
module tb_photon_cop_ctrl;
  import photon_cop_pkg::*;

  logic        cop_clk = 1'b0;
  logic        cop_rst, cop_valid, cop_rdywr;
  logic [31:0] cop_insn, cop_rs1, cop_rs2, dp_res;
  logic        cop_ready, cop_wait, cop_wr, dp_step;
  logic [31:0] cop_rd, dp_rs1, dp_rs2, dp_rd;
  logic [2:0]  dp_imm;
  logic [15:0] stat_ops;

  logic        l_valid, l_rdywr, l_ready, l_wait, l_wr, l_step;
  logic [31:0] l_insn, l_rs1, l_rs2, l_rd, l_dprs1, l_dprs2, l_dprd;
  logic [2:0]  l_imm;
  logic [15:0] l_ops;

  logic        o_ready, o_wait, o_wr, o_step;
  logic [31:0] o_rd, o_dprs1, o_dprs2;
  logic [2:0]  o_imm;
  logic [15:0] o_ops;

  int total = 0;
  int bad   = 0;

  always #5 cop_clk = ~cop_clk;

  assign dp_rd  = dp_step ? dp_res : 32'h0BAD_0BAD;
  assign l_dprd = l_step ? (l_dprs1 ^ l_dprs2) : 32'h0BAD_0BAD;

  photon_cop_ctrl #(.ISE_V(2'b10), .LAT(2)) u_dut (
    .cop_clk(cop_clk), .cop_rst(cop_rst), .cop_valid(cop_valid), .cop_rdywr(cop_rdywr),
    .cop_ready(cop_ready), .cop_wait(cop_wait), .cop_wr(cop_wr), .cop_insn(cop_insn),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2), .cop_rd(cop_rd), .dp_step(dp_step),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_imm(dp_imm), .dp_rd(dp_rd), .stat_ops(stat_ops)
  );

  photon_cop_ctrl #(.ISE_V(2'b10), .LAT(1)) u_lat1 (
    .cop_clk(cop_clk), .cop_rst(cop_rst), .cop_valid(l_valid), .cop_rdywr(l_rdywr),
    .cop_ready(l_ready), .cop_wait(l_wait), .cop_wr(l_wr), .cop_insn(l_insn),
    .cop_rs1(l_rs1), .cop_rs2(l_rs2), .cop_rd(l_rd), .dp_step(l_step),
    .dp_rs1(l_dprs1), .dp_rs2(l_dprs2), .dp_imm(l_imm), .dp_rd(l_dprd), .stat_ops(l_ops)
  );

  photon_cop_ctrl #(.ISE_V(2'b00), .LAT(2)) u_off (
    .cop_clk(cop_clk), .cop_rst(cop_rst), .cop_valid(cop_valid), .cop_rdywr(cop_rdywr),
    .cop_ready(o_ready), .cop_wait(o_wait), .cop_wr(o_wr), .cop_insn(cop_insn),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2), .cop_rd(o_rd), .dp_step(o_step),
    .dp_rs1(o_dprs1), .dp_rs2(o_dprs2), .dp_imm(o_imm), .dp_rd(dp_rd), .stat_ops(o_ops)
  );

  typedef struct {
    logic        valid, rdywr;
    logic [31:0] insn, rs1, rs2, dpres;
    logic        e_ready, e_wait, e_wr, e_step;
    logic [2:0]  e_imm;
    logic [31:0] e_rs1, e_rs2, e_rd;
    logic [15:0] e_ops;
  } vec_t;

  vec_t vt[19];

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [6:0] op);
    return {f7, 18'd0, op};
  endfunction

  function automatic vec_t mv(input logic v, input logic rw, input logic [31:0] insn,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] dr,
                              input logic er, input logic ew, input logic ewr, input logic es,
                              input logic [2:0] ei, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] erd, input logic [15:0] eo);
    vec_t t;
    t.valid = v; t.rdywr = rw; t.insn = insn; t.rs1 = a; t.rs2 = b; t.dpres = dr;
    t.e_ready = er; t.e_wait = ew; t.e_wr = ewr; t.e_step = es; t.e_imm = ei;
    t.e_rs1 = ea; t.e_rs2 = eb; t.e_rd = erd; t.e_ops = eo;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cop_clk);
    #1;
  endtask

  localparam logic [31:0] A  = 32'h1234_5678, B  = 32'h9ABC_DEF0, R  = 32'hCAFE_F00D;
  localparam logic [31:0] C  = 32'h0F0F_0001, D  = 32'h0000_0002, R2 = 32'h5A5A_A5A5;

  initial begin
    logic [31:0] s3, s5, n0, n1, s6;
    logic [15:0] exp_ops;
    s3 = mk(7'b0000011, CUSTOM_1);
    s5 = mk(7'b0000101, CUSTOM_1);
    n0 = mk(7'b0000011, CUSTOM_0);
    n1 = mk(7'b0001011, CUSTOM_1);
    s6 = mk(7'b0000110, CUSTOM_1);

    // single step, LAT=2
    vt[0]  = mv(1, 1, s3, A, B, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd0);
    vt[1]  = mv(1, 1, s3, A, B, R, 0, 1, 0, 1, 3, A, B, 0, 16'd0);
    vt[2]  = mv(1, 1, s3, A, B, R, 0, 1, 0, 1, 3, A, B, 0, 16'd0);
    vt[3]  = mv(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, R, 16'd0);
    vt[4]  = mv(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd1);
    // back-pressure: result must hold through 5 stalled cycles
    vt[5]  = mv(1, 0, s5, C, D, R2, 1, 0, 0, 0, 0, 0, 0, 0, 16'd1);
    vt[6]  = mv(1, 0, s5, C, D, R2, 0, 1, 0, 1, 5, C, D, 0, 16'd1);
    vt[7]  = mv(1, 0, s5, C, D, R2, 0, 1, 0, 1, 5, C, D, 0, 16'd1);
    for (int i = 8; i <= 12; i++)
      vt[i] = mv(0, 0, 0, 0, 0, 32'hFFFF_0000, 0, 0, 1, 0, 0, 0, 0, R2, 16'd1);
    vt[13] = mv(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, R2, 16'd1);
    vt[14] = mv(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd2);
    // non-matching instructions are ignored
    vt[15] = mv(1, 1, n0, A, B, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd2);
    vt[16] = mv(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd2);
    vt[17] = mv(1, 1, n1, A, B, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd2);
    vt[18] = mv(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd2);

    cop_rst = 1; cop_valid = 0; cop_rdywr = 0; cop_insn = 0; cop_rs1 = 0; cop_rs2 = 0; dp_res = 0;
    l_valid = 0; l_rdywr = 0; l_insn = 0; l_rs1 = 0; l_rs2 = 0;
    tick(); tick();
    cop_rst = 0;
    chk("rst_ready", 0, cop_ready, 1);
    chk("rst_wait",  0, cop_wait, 0);
    chk("rst_wr",    0, cop_wr, 0);
    chk("rst_rd",    0, cop_rd, 0);
    chk("rst_ops",   0, stat_ops, 0);
    chk("rst_step",  0, dp_step, 0);

    for (int i = 0; i < 19; i++) begin
      cop_valid = vt[i].valid; cop_rdywr = vt[i].rdywr; cop_insn = vt[i].insn;
      cop_rs1 = vt[i].rs1; cop_rs2 = vt[i].rs2; dp_res = vt[i].dpres;
      #1;
      chk("ready", i, cop_ready, vt[i].e_ready);
      chk("wait",  i, cop_wait,  vt[i].e_wait);
      chk("wr",    i, cop_wr,    vt[i].e_wr);
      chk("step",  i, dp_step,   vt[i].e_step);
      chk("imm",   i, dp_imm,    vt[i].e_imm);
      chk("dprs1", i, dp_rs1,    vt[i].e_rs1);
      chk("dprs2", i, dp_rs2,    vt[i].e_rs2);
      chk("rd",    i, cop_rd,    vt[i].e_rd);
      chk("ops",   i, stat_ops,  vt[i].e_ops);
      chk("off_wait", i, o_wait, 0);
      chk("off_wr",   i, o_wr, 0);
      chk("off_step", i, o_step, 0);
      tick();
    end

    // reset during the first EXEC cycle discards the result and clears the counter
    cop_valid = 1; cop_rdywr = 1; cop_insn = s3; cop_rs1 = A; cop_rs2 = B; dp_res = R;
    tick();
    cop_valid = 0;
    chk("mid_exec_wait", 0, cop_wait, 1);
    cop_rst = 1;
    tick();
    cop_rst = 0;
    #1;
    chk("mid_rst_ready", 0, cop_ready, 1);
    chk("mid_rst_wait",  0, cop_wait, 0);
    chk("mid_rst_ops",   0, stat_ops, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mid_rst_wr", i, cop_wr, 0);
      tick();
    end

    // LAT=1: counter wrap plus back-to-back accepts every 3 cycles
    force u_lat1.stat_q = 16'hFFFF;
    #1;
    release u_lat1.stat_q;
    #1;
    chk("l_preload", 0, l_ops, 16'hFFFF);
    l_valid = 1; l_rdywr = 1; l_insn = s6; l_rs1 = 32'hA5A5_0F0F; l_rs2 = 32'h0000_FFFF;
    exp_ops = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("l_idle_ready", k, l_ready, 1);
      chk("l_idle_wait",  k, l_wait, 0);
      chk("l_ops",        k, l_ops, exp_ops);
      tick();
      chk("l_exec_step",  k, l_step, 1);
      chk("l_exec_imm",   k, l_imm, 6);
      chk("l_exec_wr",    k, l_wr, 0);
      tick();
      chk("l_resp_wr",    k, l_wr, 1);
      chk("l_resp_rd",    k, l_rd, 32'hA5A5_F0F0);
      chk("l_resp_step",  k, l_step, 0);
      tick();
      exp_ops = exp_ops + 16'd1;
    end
    l_valid = 0;
    chk("l_final_ops", 0, l_ops, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
